// File: rtl/wb_charlieplex.sv
// wb_charlieplex: pipelined Wishbone slave driving an N-pin charlieplexed LED matrix.
// Double-buffered framebuffer, frame-synchronous swap, PWM brightness, dead time between rows.
module wb_charlieplex #(
  parameter int PINS        = 7,
  parameter int BRIGHT_BITS = 4,
  parameter int DEAD_TICKS  = 2,
  parameter int ADDR_W      = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_stall_o,
  output logic              wb_ack_o,
  output logic [PINS-1:0]   charlie_o,
  output logic [PINS-1:0]   charlie_oe,
  output logic              frame_o
);

  localparam int RW = $clog2(PINS);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(PINS - 1);
  localparam logic [BRIGHT_BITS-1:0] LAST_TICK = '1;
  localparam logic [DW-1:0] LAST_DEAD = DW'(DEAD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DEAD,
    S_FEND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_enable;
  logic [BRIGHT_BITS-1:0] r_bright;
  logic                   r_swap_pend;
  logic [PINS-2:0]        r_back  [PINS];
  logic [PINS-2:0]        r_front [PINS];
  logic [RW-1:0]          r_row;
  logic [BRIGHT_BITS-1:0] r_tick;
  logic [DW-1:0]          r_dead;
  logic                   r_ack;
  logic [31:0]            r_dat;

  logic            w_acc;
  logic            w_wr;
  logic            w_is_row;
  logic            w_is_bri;
  logic            w_is_ctl;
  logic [RW-1:0]   w_ridx;
  logic            w_swap;
  logic [31:0]     w_rdata;
  logic [PINS-1:0] w_bits;
  logic [PINS-1:0] w_src;
  logic [PINS-1:0] w_low;
  logic [PINS-1:0] w_sink;
  logic            w_lit;
  logic            w_unused;

  assign w_acc    = wb_cyc_i & wb_stb_i & ~r_swap_pend;
  assign w_wr     = w_acc & wb_we_i;
  assign w_is_row = wb_adr_i < ADDR_W'(PINS);
  assign w_is_bri = wb_adr_i == ADDR_W'(PINS);
  assign w_is_ctl = wb_adr_i == ADDR_W'(PINS + 1);
  assign w_ridx   = wb_adr_i[RW-1:0];
  assign w_unused = &{1'b0, wb_dat_i};

  // A pending swap lands at frame end, or straight away when the scan is idle.
  assign w_swap = r_swap_pend & ((r_state == S_IDLE) | (r_state == S_FEND));

  assign wb_stall_o = r_swap_pend;
  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat;
  assign frame_o    = (r_state == S_FEND);

  // Register-map read mux; unmapped addresses read zero.
  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_is_row: w_rdata = 32'(r_back[w_ridx]);
      w_is_bri: w_rdata = 32'(r_bright);
      w_is_ctl: w_rdata = {30'd0, r_swap_pend, r_enable};
      default:  w_rdata = '0;
    endcase
  end

  // Bus side: accept, registered ack/data, register writes, swap request.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_enable    <= 1'b0;
      r_bright    <= '1;
      r_swap_pend <= 1'b0;
      r_back      <= '{default: '0};
    end else begin
      r_ack <= w_acc;
      if (w_acc) begin
        r_dat <= w_rdata;
      end
      if (w_wr && w_is_row) begin
        r_back[w_ridx] <= wb_dat_i[PINS-2:0];
      end
      if (w_wr && w_is_bri) begin
        r_bright <= wb_dat_i[BRIGHT_BITS-1:0];
      end
      if (w_wr && w_is_ctl) begin
        r_enable <= wb_dat_i[0];
      end
      if (w_wr && w_is_ctl && wb_dat_i[1]) begin
        r_swap_pend <= 1'b1;
      end else if (w_swap) begin
        r_swap_pend <= 1'b0;
      end
    end
  end

  // Scan state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Scan next-state: dwell, dead time, then next row or frame end.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_enable) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (r_tick == LAST_TICK) w_next = S_DEAD;
      end
      S_DEAD: begin
        if (r_dead == LAST_DEAD) begin
          w_next = (r_row == LAST_ROW) ? S_FEND : S_DRIVE;
        end
      end
      S_FEND: begin
        w_next = r_enable ? S_DRIVE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Row/tick/dead counters and the front buffer copy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_row   <= '0;
      r_tick  <= '0;
      r_dead  <= '0;
      r_front <= '{default: '0};
    end else begin
      if (w_swap) begin
        r_front <= r_back;
      end
      unique case (r_state)
        S_DRIVE: begin
          r_tick <= r_tick + 1'b1;
          r_dead <= '0;
        end
        S_DEAD: begin
          if (r_dead == LAST_DEAD) begin
            r_dead <= '0;
            if (r_row != LAST_ROW) r_row <= r_row + 1'b1;
          end else begin
            r_dead <= r_dead + 1'b1;
          end
        end
        default: begin
          r_row  <= '0;
          r_tick <= '0;
          r_dead <= '0;
        end
      endcase
    end
  end

  // Spread the row's LED bits over every pin except the source pin.
  assign w_bits = {1'b0, r_front[r_row]};
  assign w_src  = PINS'(1) << r_row;
  assign w_low  = w_src - 1'b1;
  assign w_sink = (w_bits & w_low) | ((w_bits & ~w_low) << 1);
  assign w_lit  = r_tick < r_bright;

  // Pin drive: source high for the whole dwell, sinks low while PWM is on.
  always_comb begin
    charlie_o  = '0;
    charlie_oe = '0;
    if (r_state == S_DRIVE) begin
      charlie_o  = w_src;
      charlie_oe = w_src | (w_lit ? w_sink : '0);
    end
  end

endmodule

// File: tb/tb_wb_charlieplex.sv
// tb_wb_charlieplex: directed sequence with random data against a frame-level model.
// Model predicts each pin from frame position, row pattern and brightness.
module tb_wb_charlieplex;

  localparam int PINS  = 7;
  localparam int DWELL = 16;
  localparam int ROWT  = DWELL + 2;
  localparam int FRAME = PINS * ROWT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic [6:0]  charlie_o;
  logic [6:0]  charlie_oe;
  logic        frame_o;

  int checks = 0;
  int failures = 0;
  int m_back [PINS];
  int m_front [PINS];
  int m_bright;
  bit m_pend;
  int q;
  int n;
  int bad;
  int v3;
  int v4;

  wb_charlieplex dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_stall_o(wb_stall_o),
    .wb_ack_o  (wb_ack_o),
    .charlie_o (charlie_o),
    .charlie_oe(charlie_oe),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input bit we, input int adr, input int d,
                     output int rq);
    int k;
    k = 0;
    @(negedge clk);
    while (wb_stall_o === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("stall_wait", 32'(wb_stall_o), 0);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = 5'(adr);
    wb_dat_i = d;
    @(negedge clk);
    chk($sformatf("ack_a%0d", adr), 32'(wb_ack_o), 1);
    rq = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input int adr, input int d);
    int dummy;
    bus(1'b1, adr, d, dummy);
  endtask

  task automatic rd(input string tag, input int adr, input int exp);
    int r;
    bus(1'b0, adr, 0, r);
    chk(tag, r, exp);
  endtask

  task automatic check_frame(input string tag);
    int k;
    int row;
    int off;
    int eo;
    int eoe;
    int bi;
    k = 0;
    while (frame_o !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_sync"}, 32'(frame_o), 1);
    if (m_pend) begin
      chk({tag, "_stall"}, 32'(wb_stall_o), 1);
      m_front = m_back;
      m_pend = 1'b0;
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      eo = 0;
      eoe = 0;
      if (c < FRAME - 1) begin
        row = c / ROWT;
        off = c % ROWT;
        if (off < DWELL) begin
          eo = 1 << row;
          eoe = eo;
          for (int p = 0; p < PINS; p++) begin
            bi = (p < row) ? p : p - 1;
            if (p != row && off < m_bright && ((m_front[row] >> bi) & 1) != 0)
              eoe |= 1 << p;
          end
        end
      end
      chk($sformatf("%s_c%0d", tag, c),
          32'({frame_o, charlie_oe, charlie_o}),
          (((c == FRAME - 1) ? 1 : 0) << 14) | (eoe << 7) | eo);
      if (c == 0) chk({tag, "_nostall"}, 32'(wb_stall_o), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < PINS; i++) begin
      m_back[i] = 0;
      m_front[i] = 0;
    end
    m_bright = 15;
    m_pend = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(wb_ack_o), 0);
    chk("rst_stall", 32'(wb_stall_o), 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_oe", 32'(charlie_oe), 0);
    chk("rst_o", 32'(charlie_o), 0);
    chk("rst_frame", 32'(frame_o), 0);
    rst = 1'b0;

    rd("rd_ctrl0", PINS + 1, 0);
    rd("rd_bright0", PINS, 15);
    for (int r = 0; r < PINS; r++) rd($sformatf("rd_row%0d_0", r), r, 0);

    // random back buffer, row 2 all on
    for (int r = 0; r < PINS; r++) begin
      q = $urandom;
      if (r == 2) q = 32'h3F;
      wr(r, q);
      m_back[r] = q & 32'h3F;
    end
    for (int r = 0; r < PINS; r++)
      rd($sformatf("rd_row%0d_1", r), r, m_back[r]);

    // swap from idle plus enable
    wr(PINS + 1, 3);
    chk("idle_swap_stall", 32'(wb_stall_o), 1);
    @(negedge clk);
    chk("idle_swap_done", 32'(wb_stall_o), 0);
    m_front = m_back;
    check_frame("f_full");

    // back buffer write without swap leaves display alone
    q = $urandom;
    wr(0, q);
    m_back[0] = q & 32'h3F;
    rd("rd_row0_noswap", 0, m_back[0]);
    check_frame("f_noswap");

    // frame-synchronous swap while scanning
    for (int r = 0; r < PINS; r++) begin
      q = $urandom;
      wr(r, q);
      m_back[r] = q & 32'h3F;
    end
    wr(PINS + 1, 3);
    m_pend = 1'b1;
    chk("run_swap_stall", 32'(wb_stall_o), 1);
    check_frame("f_swap");

    // brightness zero then random
    wr(PINS, int'($urandom & 32'hFFFF_FFF0));
    m_bright = 0;
    rd("rd_bright_z", PINS, 0);
    check_frame("f_b0");
    q = $urandom_range(1, 14);
    wr(PINS, int'($urandom & 32'hFFFF_FFF0) | q);
    m_bright = q;
    rd("rd_bright_r", PINS, q);
    check_frame("f_br");

    // back-to-back writes, stb without cyc, unmapped address
    v3 = $urandom;
    v4 = $urandom;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = 1'b1;
    wb_adr_i = 5'd3;
    wb_dat_i = v3;
    @(negedge clk);
    chk("b2b_ack1", 32'(wb_ack_o), 1);
    wb_adr_i = 5'd4;
    wb_dat_i = v4;
    @(negedge clk);
    chk("b2b_ack2", 32'(wb_ack_o), 1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    m_back[3] = v3 & 32'h3F;
    m_back[4] = v4 & 32'h3F;
    @(negedge clk);
    chk("b2b_ack_off", 32'(wb_ack_o), 0);
    wb_stb_i = 1'b1;
    wb_we_i = 1'b1;
    wb_adr_i = 5'd5;
    wb_dat_i = ~m_back[5];
    @(negedge clk);
    chk("nocyc_ack", 32'(wb_ack_o), 0);
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    wr(31, $urandom);
    rd("rd_a31", 31, 0);
    for (int r = 0; r < PINS; r++)
      rd($sformatf("rd_row%0d_2", r), r, m_back[r]);

    // clear enable during row 3: frame completes, then pins released
    n = 0;
    while (frame_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("dis_sync", 32'(frame_o), 1);
    repeat (3 * ROWT + 3) @(negedge clk);
    wr(PINS + 1, 0);
    n = 3 * ROWT + 4;
    while (frame_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("dis_frame_pos", n, FRAME - 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (charlie_oe !== '0 || charlie_o !== '0 || frame_o !== 1'b0) bad++;
    end
    chk("dis_idle_pins", bad, 0);
    rd("rd_ctrl_dis", PINS + 1, 0);

    // reset during a frame
    for (int r = 0; r < PINS; r++) begin
      q = $urandom | 1;
      wr(r, q);
      m_back[r] = q & 32'h3F;
    end
    wr(PINS + 1, 3);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_oe", 32'(charlie_oe), 0);
    chk("mrst_frame", 32'(frame_o), 0);
    chk("mrst_stall", 32'(wb_stall_o), 0);
    rst = 1'b0;
    for (int i = 0; i < PINS; i++) begin
      m_back[i] = 0;
      m_front[i] = 0;
    end
    m_bright = 15;
    rd("mrst_row2", 2, 0);
    rd("mrst_bright", PINS, 15);
    rd("mrst_ctrl", PINS + 1, 0);
    wr(PINS + 1, 1);
    check_frame("f_postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
